fir_mac_sched: RTL and testbench
================================

Name: fir_mac_sched

Overview:
Scheduler that time-shares one serial FIR MAC datapath between NCH independent sample channels. The datapath is the per-channel delay lines, the tap mux, the coefficient ROM, the booth multiplier and the saturating accumulator. The block queues per-channel sample strobes and grants channels round-robin. For each granted channel it drives the channel select, tap index, accumulator clear, MAC enable and output-register load. It replaces the single-channel control-plus-tap-counter pair when several channels share one multiplier.

Parameters:
NCH, 4, number of channels sharing the MAC
CH_BITS, 2, width of channel index (ceil log2 NCH)
TAPS, 32, taps per filter run
TAP_BITS, 5, width of tap index (ceil log2 TAPS)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
sample  in  NCH  per-channel new-sample strobe, one cycle high; bit i also shifts channel i delay line externally
ovClr  in  1  clears sticky overrun flags
ch  out  CH_BITS  channel currently granted (selects delay line and output register)
qSel  out  TAP_BITS  tap index to tap mux and coefficient ROM
clr  out  1  accumulator synchronous clear
macEn  out  1  accumulator load enable
oe  out  1  one-cycle load of channel ch output register
oeCh  out  CH_BITS  channel whose result is loaded when oe=1
busy  out  1  high whenever state != IDLE
overrun  out  NCH  sticky per-channel sample-loss/corruption flag

Behaviour:
- Reset (reset=0, asynchronous) clears the following. State=IDLE. pend=0. overrun=0. ch=0, qSel=0, oeCh=0. clr, macEn, oe and busy all 0. Round-robin pointer last=NCH-1, so ch0 has first priority.
- pend[i] is set on any cycle with sample[i]=1. It is cleared when channel i is granted. If set and clear occur in the same cycle, set wins.
- States:
  - IDLE: if pend!=0, grant and go to CLR. Otherwise stay in IDLE.
  - CLR: clr=1 and qSel=0 for one cycle. Next state is RUN.
  - RUN: macEn=1. qSel increments by 1 each cycle from 0 to TAPS-1. After qSel=TAPS-1, go to DUMP. qSel never wraps mid-run.
  - DUMP: oe=1 and oeCh=ch for one cycle. If pend!=0, grant directly and go to CLR. Otherwise go to IDLE.
- Grant: choose the first set pend bit, searching upward from last+1 modulo NCH. Load ch with that index, set last to it and clear its pend bit. ch holds its value until the next grant.
- clr, macEn, oe and busy are decoded from registered state only and are glitch-free. qSel and ch are registered.
- Latency: a sample seen in cycle 0 on an idle block gives:
  - grant in cycle 1;
  - clr in cycle 2;
  - macEn in cycles 3..2+TAPS;
  - oe in cycle 3+TAPS (cycle 35 at defaults).
- Back-to-back runs have a period of TAPS+2 cycles.
- Overrun conditions (overrun[i] set in each case):
  - sample[i]=1 while pend[i]=1: the earlier request is merged and only one run occurs.
  - sample[i]=1 while ch=i and state is CLR, RUN or DUMP: the delay line shifted mid-run. pend[i] is set, so the channel is recomputed later.
- overrun is cleared by ovClr=1. If ovClr and a new overrun event occur in the same cycle, set wins.
- Reset asserted mid-run aborts immediately. No oe is issued and pending requests are lost.

Test Plan:
1. Reset held low, with sample toggling -> all outputs 0 and no state change. Reset released with sample=0 -> busy stays 0 indefinitely.
2. Single run: sample=4'b0001 in cycle 0 -> clr=1 in cycle 2; macEn=1 in cycles 3..34 with qSel=0..31; oe=1 with oeCh=0 in cycle 35; busy high in cycles 2..35. Verify by connecting the real datapath: impulse xIn=16'h7fff on ch0 -> yOut matches h[0] scaling.
3. Simultaneous requests: sample=4'b1111 in cycle 0 -> oe in cycles 35, 69, 103, 137 with oeCh=0,1,2,3, and no IDLE cycle between runs.
4. Round-robin: ch2 is running and samples on ch0 and ch3 arrive during the run -> next grant is ch3, then ch0.
5. Overrun, both cases:
  - sample[1] in cycles 0 and 1 while ch0 is running -> overrun=4'b0010 and only one ch1 run. ovClr=1 -> overrun=0.
  - sample[2] during ch2 RUN at qSel=10 -> overrun[2]=1 and a second ch2 run follows.
6. Async reset mid-RUN at qSel=10, with pend=4'b1000 -> on reset assertion, before the next edge: qSel=0, macEn=0, busy=0. After release: no oe and no ch3 run.

Source files
------------

// File: rtl/fir_mac_sched.sv
// rtl/fir_mac_sched.sv - round-robin scheduler sharing one serial FIR MAC between NCH channels
module fir_mac_sched #(
    parameter int NCH      = 4,
    parameter int CH_BITS  = 2,
    parameter int TAPS     = 32,
    parameter int TAP_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NCH-1:0]      sample,
    input  logic                ovClr,
    output logic [CH_BITS-1:0]  ch,
    output logic [TAP_BITS-1:0] qSel,
    output logic                clr,
    output logic                macEn,
    output logic                oe,
    output logic [CH_BITS-1:0]  oeCh,
    output logic                busy,
    output logic [NCH-1:0]      overrun
);

    typedef enum logic [1:0] {IDLE, CLR, RUN, DUMP} state_t;

    localparam logic [TAP_BITS-1:0] TAP_LAST = TAP_BITS'(TAPS - 1);

    state_t               state, state_n;
    logic [NCH-1:0]       pend;
    logic [CH_BITS-1:0]   last;
    logic [CH_BITS-1:0]   gnt_idx;
    logic [CH_BITS-1:0]   probe;
    logic                 gnt_any;
    logic                 grant;
    logic                 last_tap;
    logic [NCH-1:0]       gnt_mask;
    logic [NCH-1:0]       ov_evt;

    assign last_tap = (qSel == TAP_LAST);
    assign oeCh     = ch;

    // Walk downward so the channel nearest last+1 is the one that sticks.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        probe   = '0;
        for (int k = NCH; k >= 1; k--) begin
            probe = CH_BITS'((int'(last) + k) % NCH);
            if (pend[probe]) begin
                gnt_any = 1'b1;
                gnt_idx = probe;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        clr     = 1'b0;
        macEn   = 1'b0;
        oe      = 1'b0;
        busy    = (state != IDLE);
        grant   = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_any) begin
                    grant   = 1'b1;
                    state_n = CLR;
                end
            end
            CLR: begin
                clr     = 1'b1;
                state_n = RUN;
            end
            RUN: begin
                macEn = 1'b1;
                if (last_tap) begin
                    state_n = DUMP;
                end
            end
            DUMP: begin
                oe = 1'b1;
                if (gnt_any) begin
                    grant   = 1'b1;
                    state_n = CLR;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A strobe on the channel being filtered corrupts its delay line mid-run.
    always_comb begin
        gnt_mask = grant ? (NCH'(1) << gnt_idx) : '0;
        ov_evt   = sample & pend;
        if (state != IDLE) begin
            ov_evt = ov_evt | (sample & (NCH'(1) << ch));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend    <= '0;
            overrun <= '0;
            ch      <= '0;
            last    <= CH_BITS'(NCH - 1);
            qSel    <= '0;
        end else begin
            pend    <= (pend & ~gnt_mask) | sample;
            overrun <= (ovClr ? '0 : overrun) | ov_evt;
            if (grant) begin
                ch   <= gnt_idx;
                last <= gnt_idx;
            end
            qSel <= (state == RUN && !last_tap) ? qSel + TAP_BITS'(1) : '0;
        end
    end

endmodule

// File: tb/tb_fir_mac_sched.sv
// tb/tb_fir_mac_sched.sv - scoreboard bench for fir_mac_sched against a run-level reference model
module tb_fir_mac_sched;

    localparam int NCH      = 4;
    localparam int CH_BITS  = 2;
    localparam int TAPS     = 32;
    localparam int TAP_BITS = 5;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NCH-1:0]      sample = '0;
    logic                ovClr = 1'b0;
    logic [CH_BITS-1:0]  ch;
    logic [TAP_BITS-1:0] qSel;
    logic                clr;
    logic                macEn;
    logic                oe;
    logic [CH_BITS-1:0]  oeCh;
    logic                busy;
    logic [NCH-1:0]      overrun;

    fir_mac_sched #(
        .NCH(NCH), .CH_BITS(CH_BITS), .TAPS(TAPS), .TAP_BITS(TAP_BITS)
    ) dut (
        .clk(clk), .reset(reset), .sample(sample), .ovClr(ovClr),
        .ch(ch), .qSel(qSel), .clr(clr), .macEn(macEn), .oe(oe),
        .oeCh(oeCh), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          ch;
        int unsigned cyc;
    } oe_t;

    oe_t exp_q[$];
    oe_t mon_e;

    // Reference model: a run occupies cycles start..start+TAPS+1 (clr, TAPS macs, dump).
    logic [NCH-1:0] m_pend;
    logic [NCH-1:0] m_ov;
    int             m_last;
    int             m_ch;
    bit             m_active;
    int unsigned    m_start;
    bit             cur_macen;
    int             cur_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [NCH-1:0] p, input int lst);
        for (int k = 1; k <= NCH; k++) begin
            if (p[(lst + k) % NCH]) return (lst + k) % NCH;
        end
        return -1;
    endfunction

    task automatic model_init();
        m_pend   = '0;
        m_ov     = '0;
        m_last   = NCH - 1;
        m_ch     = 0;
        m_active = 1'b0;
        m_start  = 0;
        exp_q.delete();
    endtask

    task automatic step(input logic [NCH-1:0] s, input logic oc);
        int unsigned    c;
        int             rel;
        bit             dump;
        int             g;
        logic [NCH-1:0] ev;
        @(negedge clk);
        c         = cyc;
        rel       = m_active ? int'(c - m_start) : -1;
        cur_macen = m_active && rel >= 1 && rel <= TAPS;
        cur_q     = rel - 1;
        dump      = m_active && rel == TAPS + 1;
        chk("busy", busy, m_active);
        chk("clr", clr, m_active && rel == 0);
        chk("macEn", macEn, cur_macen);
        if (cur_macen) chk("qSel", qSel, cur_q);
        if (m_active) chk("ch", ch, m_ch);
        chk("overrun", overrun, m_ov);

        ev = s & m_pend;
        if (m_active && s[m_ch]) ev[m_ch] = 1'b1;
        m_ov = (oc ? '0 : m_ov) | ev;
        if ((!m_active || dump) && m_pend != '0) begin
            g          = rr_pick(m_pend, m_last);
            m_pend[g]  = 1'b0;
            m_ch       = g;
            m_last     = g;
            m_active   = 1'b1;
            m_start    = c + 1;
            exp_q.push_back('{g, c + TAPS + 2});
        end else if (dump) begin
            m_active = 1'b0;
        end
        m_pend = m_pend | s;
        sample = s;
        ovClr  = oc;
    endtask

    always @(negedge clk) begin
        if (reset && oe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL oe_unexpected: got oe with oeCh=%0d at cycle %0d, expected no oe", oeCh, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("oeCh", oeCh, mon_e.ch);
                chk("oe_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        int n;
        logic [NCH-1:0] s;
        model_init();
        #1 reset = 1'b0;

        repeat (6) begin
            @(negedge clk);
            sample = NCH'($urandom);
            chk("rst_busy", busy, 0);
            chk("rst_clr", clr, 0);
            chk("rst_macEn", macEn, 0);
            chk("rst_oe", oe, 0);
            chk("rst_qSel", qSel, 0);
            chk("rst_ch", ch, 0);
            chk("rst_oeCh", oeCh, 0);
            chk("rst_overrun", overrun, 0);
        end
        @(negedge clk);
        sample = '0;
        reset  = 1'b1;
        repeat (20) step('0, 1'b0);

        step(4'b0001, 1'b0);
        repeat (40) step('0, 1'b0);

        step(4'b1111, 1'b0);
        repeat (4 * (TAPS + 2) + 5) step('0, 1'b0);

        step(4'b0100, 1'b0);
        repeat (10) step('0, 1'b0);
        step(4'b0001, 1'b0);
        repeat (3) step('0, 1'b0);
        step(4'b1000, 1'b0);
        repeat (3 * (TAPS + 2) + 5) step('0, 1'b0);

        step(4'b0001, 1'b0);
        repeat (5) step('0, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        repeat (3) step('0, 1'b0);
        chk("ov_merge", overrun, 4'b0010);
        step('0, 1'b1);
        step('0, 1'b0);
        chk("ov_clear", overrun, 4'b0000);
        repeat (2 * (TAPS + 2) + 5) step('0, 1'b0);

        step(4'b0100, 1'b0);
        n = 0;
        do begin
            step('0, 1'b0);
            n++;
        end while (!(cur_macen && cur_q == 9) && n < 100);
        chk("wait_q9_timeout", n < 100, 1);
        step(4'b0100, 1'b0);
        step('0, 1'b0);
        chk("ov_midrun", overrun[2], 1);
        step('0, 1'b1);
        repeat (2 * (TAPS + 2) + 5) step('0, 1'b0);

        step(4'b0001, 1'b0);
        repeat (4) step('0, 1'b0);
        step(4'b1000, 1'b0);
        n = 0;
        do begin
            step('0, 1'b0);
            n++;
        end while (!(cur_macen && cur_q == 10) && n < 100);
        chk("wait_q10_timeout", n < 100, 1);
        #1 reset = 1'b0;
        #1;
        chk("abort_qSel", qSel, 0);
        chk("abort_macEn", macEn, 0);
        chk("abort_busy", busy, 0);
        chk("abort_oe", oe, 0);
        model_init();
        @(negedge clk);
        reset = 1'b1;
        repeat (80) step('0, 1'b0);

        repeat (3000) begin
            for (int i = 0; i < NCH; i++) s[i] = ($urandom_range(0, 47) == 0);
            step(s, $urandom_range(0, 99) == 0);
        end

        n = 0;
        while ((m_active || m_pend != '0) && n < 400) begin
            step('0, 1'b0);
            n++;
        end
        repeat (3) step('0, 1'b0);
        chk("drain_queue", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
